// File: rtl/zion_riscv_isa_lib_add_sub_ex_pipe_pkg.sv
// Shared definitions for the add/sub execute stage.
// Holds the op bit positions, the datapath-width helper, the per-entry
// result record carried through the output and skid registers, and the
// occupancy states of the two-entry output buffer.
package zion_riscv_isa_lib_pkg;

  // Bit positions inside the op vector.
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_W   = 2;

  // Widest datapath supported; narrower builds zero-fill the upper bits.
  localparam int XLEN_MAX = 64;

  function automatic int cpu_width(input bit rv64);
    return rv64 ? 64 : 32;
  endfunction

  // One execute result, stored in both the output (O) and skid (K) registers.
  typedef struct packed {
    logic [XLEN_MAX-1:0] rslt;
    logic                lessThan;
    logic                equal;
    logic                illegal;
  } ex_rslt_t;

  // Occupancy of the output/skid pair.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/zion_riscv_isa_lib_add_sub_ex_core.sv
// Combinational add/sub datapath with compare flags.
// Ports:
//   op           : op[0] add, op[1] sub, op[2] .W (RV64 builds only)
//   s1, s2       : operands
//   unsigned_flg : 1 selects an unsigned less-than compare
//   rslt         : result record (upper bits zero in RV32 builds)
module zion_riscv_isa_lib_add_sub_ex_core
  import zion_riscv_isa_lib_pkg::*;
#(
  parameter int RV64 = 1,
  localparam int CPU_WIDTH = cpu_width(RV64 != 0)
) (
  input  logic [RV64+1:0]     op,
  input  logic [CPU_WIDTH-1:0] s1,
  input  logic [CPU_WIDTH-1:0] s2,
  input  logic                unsigned_flg,
  output ex_rslt_t            rslt
);

  logic [CPU_WIDTH-1:0] sum;
  logic [CPU_WIDTH-1:0] diff;
  logic [CPU_WIDTH-1:0] raw;
  logic [XLEN_MAX-1:0]  rslt_ext;
  logic                 a_msb;
  logic                 b_msb;

  assign sum   = s1 + s2;
  assign diff  = s1 + ~s2 + CPU_WIDTH'(1);
  assign a_msb = s1[CPU_WIDTH-1];
  assign b_msb = s2[CPU_WIDTH-1];

  // Only the two legal encodings produce a value; 00 and 11 both yield 0.
  always_comb begin
    raw = '0;
    case (op[OP_SUB:OP_ADD])
      2'b01:   raw = sum;
      2'b10:   raw = diff;
      default: raw = '0;
    endcase
  end

  // .W narrows to 32 bits and sign-extends; it exists only in RV64 builds.
  if (RV64 != 0) begin : g_rv64
    assign rslt_ext = op[OP_W] ? {{32{raw[31]}}, raw[31:0]} : raw;
  end else begin : g_rv32
    assign rslt_ext = {32'b0, raw};
  end

  // Flags come from the full-width subtract regardless of .W. When the
  // operand signs differ the subtract can overflow, so the sign bits decide.
  always_comb begin
    rslt          = '0;
    rslt.rslt     = rslt_ext;
    rslt.illegal  = op[OP_ADD] & op[OP_SUB];
    if (op[OP_SUB]) begin
      rslt.equal    = (s1 == s2);
      rslt.lessThan = (a_msb != b_msb) ? (unsigned_flg ? b_msb : a_msb)
                                       : diff[CPU_WIDTH-1];
    end
  end

endmodule

// File: rtl/zion_riscv_isa_lib_add_sub_ex_pipe.sv
// Registered add/sub execute stage with a two-entry skid buffer.
// Decode drives iOp/iS1/iS2 under iValid/oReady; results appear one cycle
// later under oValid/iReady. oReady depends only on state, so it is a
// registered signal and never combinationally follows iReady.
// Ports:
//   iClk, iRst_n          : clock, synchronous active-low reset
//   iFlush                : drop everything buffered and the incoming entry
//   iValid, oReady        : upstream handshake
//   iOp, iS1, iS2         : operation and operands
//   iUnsignedFlg          : unsigned compare select
//   oValid, iReady        : downstream handshake
//   oRslt, oLessThan,
//   oEqual, oIllegal      : registered result of the head entry
module zion_riscv_isa_lib_add_sub_ex_pipe
  import zion_riscv_isa_lib_pkg::*;
#(
  parameter int RV64 = 1,
  localparam int CPU_WIDTH = cpu_width(RV64 != 0)
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iFlush,
  input  logic                 iValid,
  output logic                 oReady,
  input  logic [RV64+1:0]      iOp,
  input  logic [CPU_WIDTH-1:0] iS1,
  input  logic [CPU_WIDTH-1:0] iS2,
  input  logic                 iUnsignedFlg,
  output logic                 oValid,
  input  logic                 iReady,
  output logic [CPU_WIDTH-1:0] oRslt,
  output logic                 oLessThan,
  output logic                 oEqual,
  output logic                 oIllegal
);

  buf_state_e state_q, state_d;
  ex_rslt_t   o_q, o_d;
  ex_rslt_t   k_q, k_d;
  ex_rslt_t   core_out;
  logic       accept;

  zion_riscv_isa_lib_add_sub_ex_core #(.RV64(RV64)) u_core (
    .op           (iOp),
    .s1           (iS1),
    .s2           (iS2),
    .unsigned_flg (iUnsignedFlg),
    .rslt         (core_out)
  );

  assign oReady    = (state_q != BUF_FULL);
  assign oValid    = (state_q != BUF_EMPTY);
  assign accept    = iValid && oReady;
  assign oRslt     = o_q.rslt[CPU_WIDTH-1:0];
  assign oLessThan = o_q.lessThan;
  assign oEqual    = o_q.equal;
  assign oIllegal  = o_q.illegal;

  // O is always the head entry. A new entry goes straight into O when O is
  // empty or draining this cycle, otherwise into K. Flush overrides all.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    k_d     = k_q;
    if (iFlush) begin
      state_d = BUF_EMPTY;
    end else begin
      unique case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            o_d     = core_out;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && iReady) begin
            o_d = core_out;
          end else if (accept) begin
            k_d     = core_out;
            state_d = BUF_FULL;
          end else if (iReady) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (iReady) begin
            o_d     = k_q;
            state_d = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= BUF_EMPTY;
      o_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      k_q     <= k_d;
    end
  end

  // The 11 encoding is flagged but still passes through as a zero result.
  always_ff @(posedge iClk) begin
    if (iRst_n && !iFlush && accept) begin
      illegal_op_chk: assert (!(iOp[OP_ADD] && iOp[OP_SUB]))
        else $warning("add/sub execute stage received op encoding 2'b11");
    end
  end

endmodule

// File: tb/tb_zion_riscv_isa_lib_add_sub_ex_pipe.sv
// Self-checking bench: an RV32 and an RV64 instance share one stimulus
// stream and are compared every cycle against a queue-based reference.
module tb_zion_riscv_isa_lib_add_sub_ex_pipe;

  typedef struct {
    logic [63:0] rslt;
    logic        lt;
    logic        eq;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, valid, uns, ready;
  logic [2:0]  op;
  logic [63:0] s1, s2;

  logic        ready32, valid32, lt32, eq32, ill32;
  logic [31:0] rslt32;
  logic        ready64, valid64, lt64, eq64, ill64;
  logic [63:0] rslt64;

  exp_t q32[$];
  exp_t q64[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  zion_riscv_isa_lib_add_sub_ex_pipe #(.RV64(0)) dut32 (
    .iClk(clk), .iRst_n(rst_n), .iFlush(flush), .iValid(valid), .oReady(ready32),
    .iOp(op[1:0]), .iS1(s1[31:0]), .iS2(s2[31:0]), .iUnsignedFlg(uns),
    .oValid(valid32), .iReady(ready), .oRslt(rslt32), .oLessThan(lt32),
    .oEqual(eq32), .oIllegal(ill32)
  );

  zion_riscv_isa_lib_add_sub_ex_pipe #(.RV64(1)) dut64 (
    .iClk(clk), .iRst_n(rst_n), .iFlush(flush), .iValid(valid), .oReady(ready64),
    .iOp(op), .iS1(s1), .iS2(s2), .iUnsignedFlg(uns),
    .oValid(valid64), .iReady(ready), .oRslt(rslt64), .oLessThan(lt64),
    .oEqual(eq64), .oIllegal(ill64)
  );

  // Reference arithmetic written directly from the operation definitions.
  function automatic exp_t refModel(input bit rv64, input logic [2:0] o,
                                    input logic [63:0] a_in, input logic [63:0] b_in,
                                    input logic u);
    exp_t        e;
    logic [63:0] a, b, r;
    a = rv64 ? a_in : {32'b0, a_in[31:0]};
    b = rv64 ? b_in : {32'b0, b_in[31:0]};
    case (o[1:0])
      2'b01:   r = a + b;
      2'b10:   r = a - b;
      default: r = 64'd0;
    endcase
    if (!rv64) r = {32'b0, r[31:0]};
    else if (o[2]) r = {{32{r[31]}}, r[31:0]};
    e.rslt = r;
    e.ill  = (o[1:0] == 2'b11);
    e.eq   = 1'b0;
    e.lt   = 1'b0;
    if (o[1]) begin
      e.eq = (a == b);
      if (u) e.lt = (a < b);
      else if (rv64) e.lt = ($signed(a) < $signed(b));
      else e.lt = ($signed(a[31:0]) < $signed(b[31:0]));
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compares both instances with the reference occupancy and head entry.
  task automatic checkState();
    checkOutput("valid32", {63'b0, valid32}, {63'b0, q32.size() > 0});
    checkOutput("ready32", {63'b0, ready32}, {63'b0, q32.size() < 2});
    checkOutput("valid64", {63'b0, valid64}, {63'b0, q64.size() > 0});
    checkOutput("ready64", {63'b0, ready64}, {63'b0, q64.size() < 2});
    if (q32.size() > 0) begin
      checkOutput("rslt32", {32'b0, rslt32}, q32[0].rslt);
      checkOutput("lt32",   {63'b0, lt32},   {63'b0, q32[0].lt});
      checkOutput("eq32",   {63'b0, eq32},   {63'b0, q32[0].eq});
      checkOutput("ill32",  {63'b0, ill32},  {63'b0, q32[0].ill});
    end
    if (q64.size() > 0) begin
      checkOutput("rslt64", rslt64,         q64[0].rslt);
      checkOutput("lt64",   {63'b0, lt64},  {63'b0, q64[0].lt});
      checkOutput("eq64",   {63'b0, eq64},  {63'b0, q64[0].eq});
      checkOutput("ill64",  {63'b0, ill64}, {63'b0, q64[0].ill});
    end
  endtask

  // One cycle: check at the falling edge, drive, then advance the model
  // across the rising edge using only the stimulus and its own occupancy.
  task automatic applyStimulus(input logic v, input logic [2:0] o,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic u, input logic r, input logic f);
    bit acc, xfer;
    checkState();
    valid = v; op = o; s1 = a; s2 = b; uns = u; ready = r; flush = f;
    @(posedge clk);
    acc  = v && (q64.size() < 2) && !f;
    xfer = (q64.size() > 0) && r;
    if (xfer) begin
      void'(q32.pop_front());
      void'(q64.pop_front());
    end
    if (f) begin
      q32.delete();
      q64.delete();
    end else if (acc) begin
      q32.push_back(refModel(1'b0, o, a, b, u));
      q64.push_back(refModel(1'b1, o, a, b, u));
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0; valid = 1'b0; flush = 1'b0; ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    q32.delete();
    q64.delete();
    rst_n = 1'b1;
    checkOutput("rst_valid64", {63'b0, valid64}, 64'd0);
    checkOutput("rst_ready64", {63'b0, ready64}, 64'd1);
    checkOutput("rst_rslt64",  rslt64, 64'd0);
    checkOutput("rst_lt64",    {63'b0, lt64}, 64'd0);
    checkOutput("rst_eq64",    {63'b0, eq64}, 64'd0);
    checkOutput("rst_ill64",   {63'b0, ill64}, 64'd0);
    checkOutput("rst_valid32", {63'b0, valid32}, 64'd0);
    checkOutput("rst_ready32", {63'b0, ready32}, 64'd1);
    checkOutput("rst_rslt32",  {32'b0, rslt32}, 64'd0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] a, b;
    logic [2:0]  o;
    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; uns = 1'b0; ready = 1'b0;
    op = '0; s1 = '0; s2 = '0;
    @(negedge clk);
    doReset();

    // Wrap-around add in RV32.
    applyStimulus(1, 3'b001, 64'hFFFF_FFFF, 64'd1, 0, 1, 0);
    checkOutput("t1_valid32", {63'b0, valid32}, 64'd1);
    checkOutput("t1_rslt32",  {32'b0, rslt32}, 64'd0);
    checkOutput("t1_lt32",    {63'b0, lt32}, 64'd0);
    checkOutput("t1_eq32",    {63'b0, eq32}, 64'd0);

    // Signed vs unsigned compare across the sign boundary.
    applyStimulus(1, 3'b010, 64'h8000_0000, 64'd1, 0, 1, 0);
    checkOutput("t2_rslt32", {32'b0, rslt32}, 64'h7FFF_FFFF);
    checkOutput("t2_lt32_s", {63'b0, lt32}, 64'd1);
    applyStimulus(1, 3'b010, 64'h8000_0000, 64'd1, 1, 1, 0);
    checkOutput("t2_lt32_u", {63'b0, lt32}, 64'd0);

    // .W sign extension and equality in RV64.
    applyStimulus(1, 3'b101, 64'h0000_0000_7FFF_FFFF, 64'd1, 0, 1, 0);
    checkOutput("t3_rslt64", rslt64, 64'hFFFF_FFFF_8000_0000);
    applyStimulus(1, 3'b010, 64'd5, 64'd5, 0, 1, 0);
    checkOutput("t3_eq64", {63'b0, eq64}, 64'd1);
    checkOutput("t3_lt64", {63'b0, lt64}, 64'd0);
    applyStimulus(0, 3'b000, 64'd0, 64'd0, 0, 1, 0);

    // Back-pressure: B lands in the skid register, C stalls until space frees.
    applyStimulus(1, 3'b001, 64'd10, 64'd1, 0, 0, 0);
    applyStimulus(1, 3'b001, 64'd20, 64'd2, 0, 0, 0);
    checkOutput("t4_full_ready64", {63'b0, ready64}, 64'd0);
    checkOutput("t4_full_ready32", {63'b0, ready32}, 64'd0);
    applyStimulus(1, 3'b001, 64'd30, 64'd3, 0, 0, 0);
    checkOutput("t4_head64", rslt64, 64'd11);
    applyStimulus(1, 3'b001, 64'd30, 64'd3, 0, 1, 0);
    checkOutput("t4_second64", rslt64, 64'd22);
    applyStimulus(1, 3'b001, 64'd30, 64'd3, 0, 1, 0);
    checkOutput("t4_third64", rslt64, 64'd33);
    applyStimulus(0, 3'b000, 64'd0, 64'd0, 0, 1, 0);
    checkOutput("t4_drained64", {63'b0, valid64}, 64'd0);

    // Flush from FULL with a simultaneous incoming entry.
    applyStimulus(1, 3'b001, 64'd1, 64'd1, 0, 0, 0);
    applyStimulus(1, 3'b001, 64'd2, 64'd2, 0, 0, 0);
    applyStimulus(1, 3'b001, 64'd7, 64'd7, 0, 0, 1);
    checkOutput("t5_valid64", {63'b0, valid64}, 64'd0);
    checkOutput("t5_ready64", {63'b0, ready64}, 64'd1);
    applyStimulus(0, 3'b000, 64'd0, 64'd0, 0, 1, 0);
    checkOutput("t5_gone64", {63'b0, valid64}, 64'd0);

    // Illegal encoding flows through as zero, then reset while FULL.
    applyStimulus(1, 3'b011, 64'd3, 64'd2, 0, 0, 0);
    checkOutput("t6_rslt64", rslt64, 64'd0);
    checkOutput("t6_ill64",  {63'b0, ill64}, 64'd1);
    checkOutput("t6_ill32",  {63'b0, ill32}, 64'd1);
    applyStimulus(1, 3'b001, 64'd4, 64'd4, 0, 0, 0);
    doReset();

    // Randomized traffic with back-pressure and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      a = rnd64();
      b = ($urandom_range(0, 7) == 0) ? a : rnd64();
      o = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      applyStimulus(1'($urandom_range(0, 9) < 7), o, a, b, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 31) == 0));
    end

    for (int i = 0; i < 4; i++) applyStimulus(0, 3'b000, 64'd0, 64'd0, 0, 1, 0);
    checkOutput("end_valid64", {63'b0, valid64}, 64'd0);
    checkOutput("end_valid32", {63'b0, valid32}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
